// File: rtl/mac_share_arbiter.sv
// Round-robin arbiter sharing one external pipelined A*B+C unit between
// N_REQ requesters. Each accepted operation sends its requester ID down a
// tag line whose length matches the MAC latency. Results collect in a
// small FIFO. Issue is credit-limited so the FIFO can never overflow.
module mac_share_arbiter #(
    parameter int  N_REQ      = 4,
    parameter int  WIDTH      = 8,
    parameter int  OUT_WIDTH  = 16,
    parameter int  LATENCY    = 3,
    parameter int  FIFO_DEPTH = 8,
    localparam int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_c,
    output logic [WIDTH-1:0]       mac_a,
    output logic [WIDTH-1:0]       mac_b,
    output logic [WIDTH-1:0]       mac_c,
    input  logic [OUT_WIDTH-1:0]   mac_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [OUT_WIDTH-1:0]   res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int OUTS_W = $clog2(FIFO_DEPTH + LATENCY + 2);

    // Arbitration state
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              grant_any;
    logic              credit_ok;
    logic              accept;

    // Tag line: stage 0 is loaded at the accept edge, stage LATENCY
    // lines up with valid mac_data and feeds the FIFO write.
    logic [LATENCY:0]  tag_vld_q;
    logic [ID_W-1:0]   tag_id_q [0:LATENCY];

    // Result FIFO
    logic [OUT_WIDTH-1:0] data_mem [0:FIFO_DEPTH-1];
    logic [ID_W-1:0]      id_mem   [0:FIFO_DEPTH-1];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic [OUTS_W-1:0]    outstanding;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        int        idx;
        logic [ID_W-1:0] idx_w;
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_w     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx   = (int'(ptr_q) + 1 + i) % N_REQ;
            idx_w = ID_W'(idx);
            if (!grant_any && req_valid[idx_w]) begin
                grant_any    = 1'b1;
                grant[idx_w] = 1'b1;
                grant_id     = idx_w;
            end
        end
    end

    // Outstanding results = tags in flight + entries already buffered;
    // a pop this cycle deliberately does not free a credit until next cycle
    always_comb begin
        outstanding = OUTS_W'(count_q);
        for (int s = 0; s <= LATENCY; s++) begin
            outstanding = outstanding + OUTS_W'(tag_vld_q[s]);
        end
    end

    assign credit_ok = (outstanding < OUTS_W'(FIFO_DEPTH));
    assign req_ready = grant & {N_REQ{credit_ok}};
    assign accept    = grant_any & credit_ok;
    assign ptr_d     = accept ? grant_id : ptr_q;

    // Operand mux to the shared MAC; idle cycles present zeros
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept && grant[i]) begin
                mac_a = req_a[i*WIDTH +: WIDTH];
                mac_b = req_b[i*WIDTH +: WIDTH];
                mac_c = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    // Round-robin pointer; reset value gives requester 0 top priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= ID_W'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Tag line head: capture the accepted requester ID
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q[0] <= 1'b0;
            tag_id_q[0]  <= '0;
        end else begin
            tag_vld_q[0] <= accept;
            tag_id_q[0]  <= grant_id;
        end
    end

    // Remaining tag stages shift one per clock
    generate
        for (genvar gi = 1; gi <= LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tag_vld_q[gi] <= 1'b0;
                    tag_id_q[gi]  <= '0;
                end else begin
                    tag_vld_q[gi] <= tag_vld_q[gi-1];
                    tag_id_q[gi]  <= tag_id_q[gi-1];
                end
            end
        end
    endgenerate

    assign push       = tag_vld_q[LATENCY];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && res_ready;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO control registers; reset discards everything buffered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents only matter behind a valid count
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mac_data;
            id_mem[wr_ptr_q]   <= tag_id_q[LATENCY];
        end
    end

    // Head of FIFO is forced to zero when empty so stale storage never shows
    assign res_valid = !fifo_empty;
    assign res_data  = fifo_empty ? '0 : data_mem[rd_ptr_q];
    assign res_id    = fifo_empty ? '0 : id_mem[rd_ptr_q];
    assign busy      = (|tag_vld_q) || !fifo_empty;

    // The credit scheme must make a write into a full, non-draining FIFO impossible
    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Bench for mac_share_arbiter: models the external MAC pipeline, keeps a
// scoreboard of expected results in issue order, and checks grants,
// latency, backpressure/credit behaviour and asynchronous reset.
module tb_mac_share_arbiter;

    localparam int N_REQ      = 4;
    localparam int WIDTH      = 8;
    localparam int OUT_WIDTH  = 16;
    localparam int LATENCY    = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int ID_W       = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a, req_b, req_c;
    logic [WIDTH-1:0]       mac_a, mac_b, mac_c;
    logic [OUT_WIDTH-1:0]   mac_data;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [OUT_WIDTH-1:0]   res_data;
    logic [ID_W-1:0]        res_id;
    logic                   busy;

    logic [WIDTH-1:0] op_a [N_REQ];
    logic [WIDTH-1:0] op_b [N_REQ];
    logic [WIDTH-1:0] op_c [N_REQ];

    always #5 clk = ~clk;

    mac_share_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .OUT_WIDTH(OUT_WIDTH),
        .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_data(mac_data),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        req_c = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
            req_c[i*WIDTH +: WIDTH] = op_c[i];
        end
    end

    // External MAC: samples operands at an edge, result valid LATENCY edges later
    logic [OUT_WIDTH-1:0] mac_pipe [0:LATENCY];
    always @(posedge clk) begin
        mac_pipe[0] <= 16'(mac_a) * 16'(mac_b) + 16'(mac_c);
        for (int i = 1; i <= LATENCY; i++) mac_pipe[i] <= mac_pipe[i-1];
    end
    assign mac_data = mac_pipe[LATENCY];

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [OUT_WIDTH-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct packed {
        logic [N_REQ-1:0] valid;
        logic [N_REQ-1:0] ready;
    } vec_t;
    vec_t tbl [13];

    int checks = 0;
    int failures = 0;
    int acc_count = 0;

    logic                 mon_acc;
    int                   mon_acc_id;
    logic [N_REQ-1:0]     mon_ready;
    logic                 mon_rv;
    logic                 mon_busy;
    logic [OUT_WIDTH-1:0] mon_data;
    logic [ID_W-1:0]      mon_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic rand_ops(input int i);
        op_a[i] = WIDTH'($urandom);
        op_b[i] = WIDTH'($urandom);
        op_c[i] = WIDTH'($urandom);
    endtask

    // One clock: sample at the falling edge, then step past the rising edge
    task automatic cycle();
        exp_t e;
        int   g;
        @(negedge clk);
        mon_acc   = 1'b0;
        mon_ready = req_ready;
        mon_rv    = res_valid;
        mon_busy  = busy;
        mon_data  = res_data;
        mon_id    = res_id;
        if (rst_n) begin
            chk("ready_onehot", 32'($countones(req_ready) <= 1), 1);
            if (|(req_valid & req_ready)) begin
                g = 0;
                for (int i = N_REQ - 1; i >= 0; i--) if (req_valid[i] && req_ready[i]) g = i;
                mon_acc    = 1'b1;
                mon_acc_id = g;
                acc_count++;
                e.id   = ID_W'(g);
                e.data = 16'(op_a[g]) * 16'(op_b[g]) + 16'(op_c[g]);
                sb_q.push_back(e);
                chk("mac_operands", {8'h0, mac_a, mac_b, mac_c}, {8'h0, op_a[g], op_b[g], op_c[g]});
                $display("accept id=%0d a=%0d b=%0d c=%0d", g, op_a[g], op_b[g], op_c[g]);
            end else begin
                chk("mac_idle_zero", {8'h0, mac_a, mac_b, mac_c}, 0);
            end
            if (res_valid && res_ready) begin
                chk("result_expected", 32'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("res_data", res_data, e.data);
                    chk("res_id", res_id, e.id);
                    $display("result id=%0d data=%0d", res_id, res_data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic drain(input string nm);
        req_valid = '0;
        res_ready = 1'b1;
        for (int i = 0; i < 30 && (sb_q.size() != 0 || busy); i++) cycle();
        chk({nm, "_sb_empty"}, sb_q.size(), 0);
        chk({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv_cnt;
        int found;
        logic [5:0] rv_hist;
        logic [5:0] busy_hist;
        logic [OUT_WIDTH-1:0] d_at;
        logic [ID_W-1:0]      id_at;

        // Grant table: applied in order from reset (pointer starts at N_REQ-1)
        tbl[0]  = {4'b0000, 4'b0000};
        tbl[1]  = {4'b1111, 4'b0001};
        tbl[2]  = {4'b1111, 4'b0010};
        tbl[3]  = {4'b0001, 4'b0001};
        tbl[4]  = {4'b1000, 4'b1000};
        tbl[5]  = {4'b1010, 4'b0010};
        tbl[6]  = {4'b1010, 4'b1000};
        tbl[7]  = {4'b0100, 4'b0100};
        tbl[8]  = {4'b0101, 4'b0001};
        tbl[9]  = {4'b0000, 4'b0000};
        tbl[10] = {4'b0110, 4'b0010};
        tbl[11] = {4'b0100, 4'b0100};
        tbl[12] = {4'b0011, 4'b0001};

        for (int i = 0; i < N_REQ; i++) rand_ops(i);

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mac", {8'h0, mac_a, mac_b, mac_c}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven round-robin grants
        for (int i = 0; i < 13; i++) begin
            for (int r = 0; r < N_REQ; r++) rand_ops(r);
            req_valid = tbl[i].valid;
            cycle();
            chk($sformatf("grant_row%0d", i), mon_ready, tbl[i].ready);
        end
        drain("tbl");

        // Single op on requester 0: 3*5+7, latency and busy window
        do_reset();
        op_a[0] = 8'd3; op_b[0] = 8'd5; op_c[0] = 8'd7;
        req_valid = 4'b0001;
        cycle();
        chk("t1_ready", mon_ready, 4'b0001);
        req_valid = '0;
        d_at = '0; id_at = '0;
        for (int j = 0; j < 6; j++) begin
            cycle();
            rv_hist[j]   = mon_rv;
            busy_hist[j] = mon_busy;
            if (mon_rv) begin d_at = mon_data; id_at = mon_id; end
        end
        chk("t1_res_valid_timing", rv_hist, 6'b010000);
        chk("t1_busy_window", busy_hist, 6'b011111);
        chk("t1_data", d_at, 22);
        chk("t1_id", id_at, 0);

        // All requesters continuously valid: 0,1,2,3,0,... with no bubbles
        do_reset();
        for (int r = 0; r < N_REQ; r++) rand_ops(r);
        req_valid = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            cycle();
            chk("rr_accept", mon_acc, 1);
            chk("rr_order", mon_acc_id, i % N_REQ);
            if (mon_acc) rand_ops(mon_acc_id);
        end
        drain("rr");

        // Backpressure: credits cap accepts at FIFO_DEPTH
        do_reset();
        res_ready = 1'b0;
        acc_count = 0;
        req_valid = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (mon_acc) rand_ops(mon_acc_id);
        end
        chk("bp_accepts", acc_count, FIFO_DEPTH);
        chk("bp_ready_zero", mon_ready, 0);
        chk("bp_res_valid", mon_rv, 1);

        // One-cycle pop pulse while full
        res_ready = 1'b1;
        cycle();
        chk("pulse_no_same_cycle_credit", mon_ready, 0);
        chk("pulse_single_pop", sb_q.size(), FIFO_DEPTH - 1);
        res_ready = 1'b0;
        cycle();
        chk("pulse_credit_accept", mon_acc, 1);
        if (mon_acc) rand_ops(mon_acc_id);
        cycle();
        chk("pulse_full_again", mon_ready, 0);
        chk("pulse_accept_total", acc_count, FIFO_DEPTH + 1);

        // Release backpressure with requesters still valid
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (mon_acc) rand_ops(mon_acc_id);
        end
        drain("bp");

        // Maximum operands on requester 3
        do_reset();
        op_a[3] = 8'd255; op_b[3] = 8'd255; op_c[3] = 8'd255;
        req_valid = 4'b1000;
        cycle();
        chk("max_ready", mon_ready, 4'b1000);
        req_valid = '0;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            cycle();
            if (mon_rv) begin
                found = 1;
                d_at  = mon_data;
                id_at = mon_id;
            end
        end
        chk("max_result_seen", found, 1);
        chk("max_data", d_at, 65280);
        chk("max_id", id_at, 3);
        drain("max");

        // Reset in the middle of two in-flight operations
        do_reset();
        for (int r = 0; r < N_REQ; r++) rand_ops(r);
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0010;
        cycle();
        req_valid = '0;
        cycle();
        chk("mid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_ready", req_ready, 0);
        cycle();
        rst_n = 1'b1;
        sb_q.delete();
        res_ready = 1'b1;
        rv_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (mon_rv) rv_cnt++;
        end
        chk("mid_no_stale_result", rv_cnt, 0);
        req_valid = 4'b1111;
        cycle();
        chk("mid_rr_restart", mon_ready, 4'b0001);
        drain("mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
